// File: rtl/asignador_voces_pkg.sv
// Shared synthesizer definitions: note numbering, index widths and a small voice-count helper.
package asignador_voces_pkg;

  localparam int N_NOTAS = 12;
  localparam int NOTA_W  = 4;
  localparam int RANK_W  = 3;

  typedef enum logic [NOTA_W-1:0] {
    DO    = 4'd0,
    DO_S  = 4'd1,
    RE    = 4'd2,
    RE_S  = 4'd3,
    MI    = 4'd4,
    FA    = 4'd5,
    FA_S  = 4'd6,
    SOL   = 4'd7,
    SOL_S = 4'd8,
    LA    = 4'd9,
    LA_S  = 4'd10,
    SI    = 4'd11
  } nota_e;

  function automatic logic [3:0] cuenta_voces(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/asignador_voces_sincronizador_flanco.sv
// Two-flop synchronizer for asynchronous button levels, plus rising/falling edge detect
// against a third flop.
module sincronizador_flanco #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] sube,
  output logic [W-1:0] baja
);

  logic [W-1:0] s1_q, s1_d;
  logic [W-1:0] s2_q, s2_d;
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign sube = s2_q & ~prev_q;
  assign baja = ~s2_q & prev_q;

endmodule

// File: rtl/asignador_voces.sv
// Polyphonic voice allocator: queues note press/release events and maps them onto a
// fixed pool of tone-generator voices, stealing the least recently allocated voice when full.
module asignador_voces
  import asignador_voces_pkg::NOTA_W, asignador_voces_pkg::RANK_W,
         asignador_voces_pkg::cuenta_voces;
#(
  parameter int N_VOCES = 4,
  parameter int N_NOTAS = asignador_voces_pkg::N_NOTAS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_NOTAS-1:0]    notas,
  output logic [N_VOCES-1:0]    voz_activa,
  output logic [4*N_VOCES-1:0]  voz_nota,
  output logic                  robo,
  output logic [3:0]            ocupadas
);

  localparam int VOZ_W = $clog2(N_VOCES);

  logic [N_NOTAS-1:0] sube, baja;
  logic [N_NOTAS-1:0] pend_press_q, pend_press_d;
  logic [N_NOTAS-1:0] pend_rel_q, pend_rel_d;
  logic [N_VOCES-1:0] activa_q, activa_d;
  logic [NOTA_W-1:0]  nota_q [N_VOCES];
  logic [NOTA_W-1:0]  nota_d [N_VOCES];
  logic [RANK_W-1:0]  rank_q [N_VOCES];
  logic [RANK_W-1:0]  rank_d [N_VOCES];
  logic               robo_q, robo_d;
  logic [3:0]         ocupadas_q, ocupadas_d;

  logic [NOTA_W-1:0]  rel_idx, press_idx;
  logic [VOZ_W-1:0]   libre_idx, lru_idx, voz_sel;
  logic               hay_libre, ya_sonando;

  sincronizador_flanco #(.W(N_NOTAS)) u_sinc (
    .clk  (clk),
    .rst  (rst),
    .d    (notas),
    .sube (sube),
    .baja (baja)
  );

  // Descending loops so the lowest matching index is the last one written.
  always_comb begin
    rel_idx    = '0;
    press_idx  = '0;
    for (int i = N_NOTAS-1; i >= 0; i--) begin
      if (pend_rel_q[i])   rel_idx   = NOTA_W'(i);
      if (pend_press_q[i]) press_idx = NOTA_W'(i);
    end
    libre_idx  = '0;
    lru_idx    = '0;
    hay_libre  = 1'b0;
    ya_sonando = 1'b0;
    for (int k = N_VOCES-1; k >= 0; k--) begin
      if (!activa_q[k]) begin
        libre_idx = VOZ_W'(k);
        hay_libre = 1'b1;
      end
      if (rank_q[k] == '0) lru_idx = VOZ_W'(k);
      if (activa_q[k] && (nota_q[k] == press_idx)) ya_sonando = 1'b1;
    end
    voz_sel = hay_libre ? libre_idx : lru_idx;
  end

  always_comb begin
    pend_press_d = pend_press_q;
    pend_rel_d   = pend_rel_q;
    activa_d     = activa_q;
    nota_d       = nota_q;
    rank_d       = rank_q;
    robo_d       = 1'b0;

    if (pend_rel_q != '0) begin
      pend_rel_d[rel_idx] = 1'b0;
      for (int k = 0; k < N_VOCES; k++) begin
        if (activa_q[k] && (nota_q[k] == rel_idx)) activa_d[k] = 1'b0;
      end
    end else if (pend_press_q != '0) begin
      pend_press_d[press_idx] = 1'b0;
      // A note already sounding keeps its voice so it is never held twice.
      if (!ya_sonando) begin
        activa_d[voz_sel] = 1'b1;
        nota_d[voz_sel]   = press_idx;
        robo_d            = !hay_libre;
        for (int k = 0; k < N_VOCES; k++) begin
          if (rank_q[k] > rank_q[voz_sel]) rank_d[k] = rank_q[k] - RANK_W'(1);
        end
        rank_d[voz_sel] = RANK_W'(N_VOCES-1);
      end
    end

    pend_press_d = (pend_press_d | sube) & ~baja;
    pend_rel_d   = pend_rel_d | baja;

    if (!en) begin
      pend_press_d = '0;
      pend_rel_d   = '0;
      activa_d     = '0;
      nota_d       = nota_q;
      rank_d       = rank_q;
      robo_d       = 1'b0;
    end

    ocupadas_d = cuenta_voces(8'(activa_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      activa_q     <= '0;
      robo_q       <= 1'b0;
      ocupadas_q   <= '0;
      for (int k = 0; k < N_VOCES; k++) begin
        nota_q[k] <= '0;
        rank_q[k] <= RANK_W'(k);
      end
    end else begin
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      activa_q     <= activa_d;
      robo_q       <= robo_d;
      ocupadas_q   <= ocupadas_d;
      for (int k = 0; k < N_VOCES; k++) begin
        nota_q[k] <= nota_d[k];
        rank_q[k] <= rank_d[k];
      end
    end
  end

  for (genvar g = 0; g < N_VOCES; g++) begin : g_nota
    assign voz_nota[4*g +: 4] = nota_q[g];
  end

  assign voz_activa = activa_q;
  assign robo       = robo_q;
  assign ocupadas   = ocupadas_q;

endmodule

// File: tb/tb_asignador_voces.sv
// Bench for asignador_voces: directed scenarios plus random button traffic, every cycle
// checked against a timestamp-based voice allocation model through an expected queue.
module tb_asignador_voces;
  import asignador_voces_pkg::*;

  localparam int NV = 4;
  localparam int NN = 12;
  localparam int W  = NV + 4*NV + 1 + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [NN-1:0] notas = '0;
  logic [NV-1:0] voz_activa;
  logic [4*NV-1:0] voz_nota;
  logic          robo;
  logic [3:0]    ocupadas;

  asignador_voces #(.N_VOCES(NV), .N_NOTAS(NN)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .notas      (notas),
    .voz_activa (voz_activa),
    .voz_nota   (voz_nota),
    .robo       (robo),
    .ocupadas   (ocupadas)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int robo_seen = 0;

  // ---------------- reference model ----------------
  bit [NN-1:0] hist[$] = '{12'h0, 12'h0, 12'h0, 12'h0};
  bit [NN-1:0] m_press = '0;
  bit [NN-1:0] m_rel   = '0;
  bit [NV-1:0] m_act   = '0;
  int m_note  [NV] = '{0, 0, 0, 0};
  int m_stamp [NV] = '{-4, -3, -2, -1};
  int m_time = 0;

  function automatic int lowest(input bit [NN-1:0] v);
    for (int i = 0; i < NN; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [NN-1:0] n);
    bit [NN-1:0] rise, fall, older, newer;
    bit robo_m;
    bit held;
    int idx, v, cnt;
    logic [4*NV-1:0] nv;
    logic [W-1:0] exp_v;
    m_time++;
    robo_m = 1'b0;
    if (r) begin
      hist.delete();
      repeat (4) hist.push_back('0);
      m_press = '0;
      m_rel   = '0;
      m_act   = '0;
      for (int k = 0; k < NV; k++) begin
        m_note[k]  = 0;
        m_stamp[k] = k - NV;
      end
    end else begin
      hist.push_back(n);
      if (hist.size() > 4) void'(hist.pop_front());
      older = hist[0];
      newer = hist[1];
      rise  = newer & ~older;
      fall  = ~newer & older;
      if (!e) begin
        m_act   = '0;
        m_press = '0;
        m_rel   = '0;
      end else begin
        if (m_rel != 0) begin
          idx = lowest(m_rel);
          m_rel[idx] = 1'b0;
          for (int k = 0; k < NV; k++) if (m_act[k] && m_note[k] == idx) m_act[k] = 1'b0;
        end else if (m_press != 0) begin
          idx = lowest(m_press);
          m_press[idx] = 1'b0;
          held = 1'b0;
          for (int k = 0; k < NV; k++) if (m_act[k] && m_note[k] == idx) held = 1'b1;
          if (!held) begin
            v = -1;
            for (int k = NV-1; k >= 0; k--) if (!m_act[k]) v = k;
            if (v < 0) begin
              v = 0;
              for (int k = 1; k < NV; k++) if (m_stamp[k] < m_stamp[v]) v = k;
              robo_m = 1'b1;
            end
            m_act[v]   = 1'b1;
            m_note[v]  = idx;
            m_stamp[v] = m_time;
          end
        end
        m_press = (m_press | rise) & ~fall;
        m_rel   = m_rel | fall;
      end
    end
    cnt = 0;
    for (int k = 0; k < NV; k++) begin
      nv[4*k +: 4] = 4'(m_note[k]);
      cnt += int'(m_act[k]);
    end
    exp_v = {m_act, nv, robo_m, 4'(cnt)};
    exp_q.push_back(exp_v);
  endtask

  // ---------------- driver tasks ----------------
  logic [NN-1:0] cur = '0;

  task automatic cycle(input logic r, input logic e, input logic [NN-1:0] n);
    @(negedge clk);
    rst   = r;
    en    = e;
    notas = n;
    model_step(r, e, n);
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, 1'b1, cur);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] exp_v, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got   = {voz_activa, voz_nota, robo, ocupadas};
        n_cmp++;
        if (got !== exp_v) begin
          n_err++;
          $display("FAIL out t=%0t got act=%b nota=%h robo=%b ocup=%0d want act=%b nota=%h robo=%b ocup=%0d",
                   $time, got[W-1 -: NV], got[W-NV-1 -: 4*NV], got[4], got[3:0],
                   exp_v[W-1 -: NV], exp_v[W-NV-1 -: 4*NV], exp_v[4], exp_v[3:0]);
        end
        if (robo === 1'b1) robo_seen++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r0;
    logic r, e;

    repeat (3) cycle(1'b1, 1'b1, '0);
    chk("reset_act", 16'(voz_activa), 16'h0);
    chk("reset_nota", voz_nota, 16'h0);
    chk("reset_ocup", 16'(ocupadas), 16'h0);

    // single press and release of Do
    cur[DO] = 1'b1;
    idle(6);
    chk("do_act", 16'(voz_activa), 16'h1);
    chk("do_ocup", 16'(ocupadas), 16'h1);
    cur = '0;
    idle(6);
    chk("do_rel_act", 16'(voz_activa), 16'h0);

    // fill all voices, then steal with La
    cur[DO] = 1'b1;  idle(5);
    cur[MI] = 1'b1;  idle(5);
    cur[SOL] = 1'b1; idle(5);
    cur[SI] = 1'b1;  idle(5);
    r0 = robo_seen;
    cur[LA] = 1'b1;  idle(6);
    chk("steal_nota", voz_nota, 16'hB749);
    chk("steal_ocup", 16'(ocupadas), 16'h4);
    chk("steal_robo_cnt", 16'(robo_seen - r0), 16'h1);
    cur = '0;
    idle(10);

    // three simultaneous presses
    cur[RE] = 1'b1; cur[FA] = 1'b1; cur[LA] = 1'b1;
    idle(8);
    chk("simul_act", 16'(voz_activa), 16'h7);
    chk("simul_nota", 16'(voz_nota[11:0]), 16'h952);

    // release and press in one cycle with a full pool
    cur[MI] = 1'b1;
    idle(6);
    chk("full_act", 16'(voz_activa), 16'hF);
    r0 = robo_seen;
    cur[MI] = 1'b0; cur[DO_S] = 1'b1;
    idle(6);
    chk("swap_nota3", 16'(voz_nota[15:12]), 16'h1);
    chk("swap_act", 16'(voz_activa), 16'hF);
    chk("swap_robo_cnt", 16'(robo_seen - r0), 16'h0);

    // drop enable with three held notes
    cur[DO_S] = 1'b0;
    idle(6);
    cycle(1'b0, 1'b0, cur);
    idle(8);
    chk("en_act", 16'(voz_activa), 16'h0);
    chk("en_ocup", 16'(ocupadas), 16'h0);
    cur[SOL] = 1'b1;
    idle(6);
    chk("en_repress_act", 16'(voz_activa), 16'h1);
    chk("en_repress_nota", 16'(voz_nota[3:0]), 16'h7);

    // reset with a full pool and a press in flight
    cur[DO] = 1'b1; cur[MI] = 1'b1; cur[SI] = 1'b1;
    idle(8);
    chk("pre_rst_act", 16'(voz_activa), 16'hF);
    cur[FA_S] = 1'b1;
    idle(3);
    cycle(1'b1, 1'b1, cur);
    cycle(1'b0, 1'b1, cur);
    chk("rst_act", 16'(voz_activa), 16'h0);
    chk("rst_nota", voz_nota, 16'h0);
    chk("rst_ocup", 16'(ocupadas), 16'h0);
    idle(14);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) cur[$urandom_range(0, NN-1)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) cur[$urandom_range(0, NN-1)] ^= 1'b1;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 79) != 0);
      cycle(r, e, cur);
    end
    cur = '0;
    idle(20);

    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
